// File: rtl/rc4_encrypt.sv
// Purpose: RC4 PRGA over an already key-scheduled S in s_memory; each keystream byte is
//          XORed with the plaintext ROM byte and written to the ciphertext RAM.
// Latency: 8 cycles per byte; byte k written 8(k+1) cycles after start is seen in IDLE,
//          finish rises one cycle after the last write.
// Backpressure: none; start is a level request, dropping it mid-run aborts to IDLE and
//          suppresses writes in that same cycle.
// Optional feature: define RC4_ENC_DROP_EN to discard the first DROP_LEN keystream bytes.
// Ports:
//   clk, reset             : clock, synchronous active-high reset
//   start, finish          : level request / run-complete flag (high in DONE)
//   s_addr/s_data/s_wren   : S memory port, s_q returns read data one cycle after address
//   msg_addr/msg_q         : plaintext ROM, 1-cycle read latency
//   ct_addr/ct_data/ct_wren: ciphertext RAM write port
module rc4_encrypt #(
    parameter int MSG_LEN  = 32,
    parameter int AW       = (MSG_LEN > 1) ? $clog2(MSG_LEN) : 1,
    parameter int DROP_LEN = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    output logic          finish,
    output logic [7:0]    s_addr,
    output logic [7:0]    s_data,
    output logic          s_wren,
    input  logic [7:0]    s_q,
    output logic [AW-1:0] msg_addr,
    input  logic [7:0]    msg_q,
    output logic [AW-1:0] ct_addr,
    output logic [7:0]    ct_data,
    output logic          ct_wren
);

    typedef enum logic [3:0] {
        IDLE, RD_I, LD_I, RD_J, LD_J, WR_I, WR_J, RD_F, LD_F, DONE
    } state_t;

    state_t        state;
    logic [7:0]    i;
    logic [7:0]    j;
    logic [7:0]    si;
    logic [7:0]    sj;
    logic [AW-1:0] k;
    logic          last_byte;
    logic          dropping;

    assign last_byte = (k == AW'(MSG_LEN - 1));

`ifdef RC4_ENC_DROP_EN
    localparam int DW = (DROP_LEN > 0) ? $clog2(DROP_LEN + 1) : 1;
    logic [DW-1:0] drop_cnt;

    // A round is discarded until DROP_LEN rounds have completed.
    assign dropping = (drop_cnt != DW'(DROP_LEN));
`else
    // DROP_LEN is kept in the parameter list so both builds share one interface.
    assign dropping = 1'b0 & (DROP_LEN != 0);
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            i     <= '0;
            j     <= '0;
            k     <= '0;
            si    <= '0;
            sj    <= '0;
`ifdef RC4_ENC_DROP_EN
            drop_cnt <= '0;
`endif
        end else if (!start && state != IDLE && state != DONE) begin
            // Abort: S and ciphertext are left partially updated.
            state <= IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        i     <= 8'd1;
                        j     <= 8'd0;
                        k     <= '0;
`ifdef RC4_ENC_DROP_EN
                        drop_cnt <= '0;
`endif
                        state <= RD_I;
                    end
                end
                RD_I: state <= LD_I;
                LD_I: begin
                    si    <= s_q;
                    j     <= j + s_q;
                    state <= RD_J;
                end
                RD_J: state <= LD_J;
                LD_J: begin
                    sj    <= s_q;
                    state <= WR_I;
                end
                WR_I: state <= WR_J;
                WR_J: state <= RD_F;
                RD_F: state <= LD_F;
                LD_F: begin
                    // i wraps 255->0 naturally for long messages.
                    i <= i + 8'd1;
`ifdef RC4_ENC_DROP_EN
                    if (dropping) begin
                        drop_cnt <= drop_cnt + 1'b1;
                        state    <= RD_I;
                    end else
`endif
                    begin
                        k     <= k + 1'b1;
                        state <= last_byte ? DONE : RD_I;
                    end
                end
                DONE: begin
                    if (!start) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Moore decode of the current state. Write enables are additionally gated by start
    // (so an abort cycle writes nothing) and by reset (no write while reset is applied).
    // When i==j the WR_J write lands on the same address last, leaving si: a valid self-swap.
    always_comb begin
        finish   = 1'b0;
        s_addr   = '0;
        s_data   = '0;
        s_wren   = 1'b0;
        msg_addr = '0;
        ct_addr  = '0;
        ct_data  = '0;
        ct_wren  = 1'b0;
        case (state)
            RD_I: s_addr = i;
            RD_J: s_addr = j;
            WR_I: begin
                s_addr = i;
                s_data = sj;
                s_wren = start & ~reset;
            end
            WR_J: begin
                s_addr = j;
                s_data = si;
                s_wren = start & ~reset;
            end
            RD_F: begin
                s_addr   = si + sj;
                msg_addr = k;
            end
            LD_F: begin
                ct_addr = k;
                ct_data = s_q ^ msg_q;
                ct_wren = start & ~reset & ~dropping;
            end
            DONE:    finish = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_rc4_encrypt.sv
module tb_rc4_encrypt;

    localparam int LA  = 32;
    localparam int AWA = 5;
    localparam int LB  = 300;
    localparam int AWB = 9;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset = 1'b1;
    int   cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Instance A: 32-byte message
    logic           a_start = 1'b0;
    logic           a_finish, a_s_wren, a_ct_wren;
    logic [7:0]     a_s_addr, a_s_data, a_s_q, a_msg_q, a_ct_data;
    logic [AWA-1:0] a_msg_addr, a_ct_addr;
    // Instance B: 300-byte message (i wraps)
    logic           b_start = 1'b0;
    logic           b_finish, b_s_wren, b_ct_wren;
    logic [7:0]     b_s_addr, b_s_data, b_s_q, b_msg_q, b_ct_data;
    logic [AWB-1:0] b_msg_addr, b_ct_addr;

    rc4_encrypt #(.MSG_LEN(LA), .AW(AWA)) u_a (
        .clk(clk), .reset(reset), .start(a_start), .finish(a_finish),
        .s_addr(a_s_addr), .s_data(a_s_data), .s_wren(a_s_wren), .s_q(a_s_q),
        .msg_addr(a_msg_addr), .msg_q(a_msg_q),
        .ct_addr(a_ct_addr), .ct_data(a_ct_data), .ct_wren(a_ct_wren)
    );

    rc4_encrypt #(.MSG_LEN(LB), .AW(AWB)) u_b (
        .clk(clk), .reset(reset), .start(b_start), .finish(b_finish),
        .s_addr(b_s_addr), .s_data(b_s_data), .s_wren(b_s_wren), .s_q(b_s_q),
        .msg_addr(b_msg_addr), .msg_q(b_msg_q),
        .ct_addr(b_ct_addr), .ct_data(b_ct_data), .ct_wren(b_ct_wren)
    );

    // Memories around the DUTs
    logic [7:0] rom    [1024];
    logic [7:0] ld_s   [256];
    logic [7:0] a_smem [256];
    logic [7:0] b_smem [256];
    logic [7:0] a_ct   [LA];
    logic [7:0] b_ct   [LB];
    logic       mem_init = 1'b0;

    always @(posedge clk) begin
        if (mem_init) begin
            a_smem <= ld_s;
            b_smem <= ld_s;
            for (int x = 0; x < LA; x++) a_ct[x] <= 8'h00;
            for (int x = 0; x < LB; x++) b_ct[x] <= 8'h00;
        end else begin
            if (a_s_wren)  a_smem[a_s_addr] <= a_s_data;
            if (b_s_wren)  b_smem[b_s_addr] <= b_s_data;
            if (a_ct_wren) a_ct[a_ct_addr]  <= a_ct_data;
            if (b_ct_wren) b_ct[b_ct_addr]  <= b_ct_data;
        end
        a_s_q   <= a_smem[a_s_addr];
        b_s_q   <= b_smem[b_s_addr];
        a_msg_q <= rom[a_msg_addr];
        b_msg_q <= rom[b_msg_addr];
    end

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, required 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference: textbook RC4 PRGA on a copy of the loaded S
    logic [7:0] m_s  [256];
    logic [7:0] m_ct [1024];

    task automatic model_run(input int n);
        int         mi = 0;
        int         mj = 0;
        logic [7:0] t;
        m_s = ld_s;
        for (int n_k = 0; n_k < n; n_k++) begin
            mi = (mi + 1) % 256;
            mj = (mj + int'(m_s[mi])) % 256;
            t = m_s[mi]; m_s[mi] = m_s[mj]; m_s[mj] = t;
            m_ct[n_k] = m_s[(int'(m_s[mi]) + int'(m_s[mj])) % 256] ^ rom[n_k];
        end
    endtask

    // Per-cycle compare: every ciphertext write and S write is checked against the model
    int a_base = 0, b_base = 0;
    bit a_run = 1'b0, a_run_q = 1'b0, b_run = 1'b0, b_run_q = 1'b0;
    int a_nwr = 0, a_fin = -1, b_nwr = 0, b_fin = -1;

    always begin
        @(negedge clk);
        #1;
        if (a_run && !a_run_q) begin a_nwr = 0; a_fin = -1; end
        if (b_run && !b_run_q) begin b_nwr = 0; b_fin = -1; end
        a_run_q = a_run;
        b_run_q = b_run;
        if (a_run) begin
            if (a_ct_wren) begin
                chk("a_ct_addr", a_ct_addr, a_nwr);
                chk("a_ct_data", a_ct_data, m_ct[a_nwr % 1024]);
                chk("a_ct_cycle", cyc - a_base, 8 * (a_nwr + 1));
                a_nwr++;
            end
            if (a_s_wren) chk("a_s_wren_slot", ((cyc - a_base) % 8) inside {5, 6}, 1);
            if (a_finish && a_fin < 0) a_fin = cyc - a_base;
        end
        if (b_run) begin
            if (b_ct_wren) begin
                chk("b_ct_addr", b_ct_addr, b_nwr);
                chk("b_ct_data", b_ct_data, m_ct[b_nwr % 1024]);
                chk("b_ct_cycle", cyc - b_base, 8 * (b_nwr + 1));
                b_nwr++;
            end
            if (b_s_wren) chk("b_s_wren_slot", ((cyc - b_base) % 8) inside {5, 6}, 1);
            if (b_finish && b_fin < 0) b_fin = cyc - b_base;
        end
    end

    task automatic until_rel(input int base, input int rel);
        while (cyc - base < rel) @(negedge clk);
    endtask

    task automatic pulse_init();
        @(negedge clk); mem_init = 1'b1;
        @(negedge clk); mem_init = 1'b0;
    endtask

    task automatic set_ident();
        for (int x = 0; x < 256; x++) ld_s[x] = 8'(x);
    endtask

    task automatic set_rand_perm();
        set_ident();
        for (int x = 255; x > 0; x--) begin
            int         y;
            logic [7:0] t;
            y = int'($urandom_range(x, 0));
            t = ld_s[x]; ld_s[x] = ld_s[y]; ld_s[y] = t;
        end
    endtask

    task automatic set_rom(input bit rnd);
        for (int x = 0; x < 1024; x++) rom[x] = rnd ? 8'($urandom) : 8'h00;
    endtask

    task automatic chk_zero_a(input string name);
        chk(name, {a_finish, a_s_addr, a_s_data, a_s_wren, a_msg_addr, a_ct_addr, a_ct_data, a_ct_wren}, 0);
    endtask

    task automatic chk_zero_b(input string name);
        chk(name, {b_finish, b_s_addr, b_s_data, b_s_wren, b_msg_addr, b_ct_addr, b_ct_data, b_ct_wren}, 0);
    endtask

    task automatic chk_rams_a(input string name, input int nct);
        int bad_ct = 0;
        int bad_s  = 0;
        for (int x = 0; x < LA; x++) if (a_ct[x] !== ((x < nct) ? m_ct[x] : 8'h00)) bad_ct++;
        for (int x = 0; x < 256; x++) if (a_smem[x] !== m_s[x]) bad_s++;
        chk({name, "_ct_ram_bad"}, bad_ct, 0);
        chk({name, "_s_ram_bad"}, bad_s, 0);
    endtask

    task automatic start_a();
        @(negedge clk);
        a_base  = cyc;
        a_run   = 1'b1;
        a_start = 1'b1;
    endtask

    task automatic full_run_a(input string name);
        pulse_init();
        model_run(LA);
        start_a();
        until_rel(a_base, 8 * LA + 6);
        chk({name, "_finish_cycle"}, a_fin, 8 * LA + 1);
        chk({name, "_finish_held"}, a_finish, 1);
        chk({name, "_writes"}, a_nwr, LA);
        chk_rams_a(name, LA);
        a_start = 1'b0;
        a_run   = 1'b0;
        @(negedge clk);
        #1;
        chk_zero_a({name, "_idle_after"});
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        set_ident();
        set_rom(1'b0);
        repeat (3) @(negedge clk);
        #1;
        chk_zero_a("reset_outputs_a");
        chk_zero_b("reset_outputs_b");
        reset = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        chk_zero_a("idle_no_start_a");

        // Identity S, zero plaintext; pin the model against hand-computed values
        set_ident();
        set_rom(1'b0);
        model_run(3);
        chk("model_ct0", m_ct[0], 8'h02);
        chk("model_ct1", m_ct[1], 8'h05);
        chk("model_ct2", m_ct[2], 8'h07);
        chk("model_s1", m_s[1], 8'h01);
        chk("model_s2", m_s[2], 8'h03);
        chk("model_s3", m_s[3], 8'h05);
        chk("model_s5", m_s[5], 8'h02);
        full_run_a("ident_zero");
        chk("ident_ct0", a_ct[0], 8'h02);
        chk("ident_ct1", a_ct[1], 8'h05);
        chk("ident_ct2", a_ct[2], 8'h07);

        // Plaintext XOR
        set_ident();
        rom[0] = 8'hFF; rom[1] = 8'hFF; rom[2] = 8'hFF;
        full_run_a("pt_xor");
        chk("xor_ct0", a_ct[0], 8'hFD);
        chk("xor_ct1", a_ct[1], 8'hFA);
        chk("xor_ct2", a_ct[2], 8'hF8);

        // Randomized S permutations and plaintexts
        for (int r = 0; r < 3; r++) begin
            set_rand_perm();
            set_rom(1'b1);
            full_run_a("random");
        end

        // Abort in cycle 12
        set_ident();
        set_rom(1'b0);
        pulse_init();
        model_run(1);
        start_a();
        until_rel(a_base, 12);
        a_start = 1'b0;
        #1;
        chk("abort12_s_wren", a_s_wren, 0);
        until_rel(a_base, 13);
        #1;
        chk_zero_a("abort12_idle_c13");
        until_rel(a_base, 40);
        chk("abort12_writes", a_nwr, 1);
        chk("abort12_ct0", a_ct[0], 8'h02);
        chk("abort12_ct1", a_ct[1], 8'h00);
        a_run = 1'b0;

        // Abort during the WR_I slot of round 2: S must reflect round 1 only
        set_rand_perm();
        set_rom(1'b1);
        pulse_init();
        model_run(1);
        start_a();
        until_rel(a_base, 13);
        a_start = 1'b0;
        #1;
        chk("abort13_s_wren", a_s_wren, 0);
        until_rel(a_base, 30);
        chk("abort13_writes", a_nwr, 1);
        chk_rams_a("abort13", 1);
        a_run = 1'b0;

        // Reset in cycle 20, then a clean re-run
        set_ident();
        set_rom(1'b0);
        pulse_init();
        model_run(LA);
        start_a();
        until_rel(a_base, 20);
        reset = 1'b1;
        until_rel(a_base, 21);
        #1;
        chk_zero_a("reset_mid_c21");
        a_start = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        chk_zero_a("reset_mid_idle");
        a_run = 1'b0;
        full_run_a("rerun");
        chk("rerun_ct0", a_ct[0], 8'h02);
        chk("rerun_ct2", a_ct[2], 8'h07);

        // 300-byte message: i wraps 255->0
        set_ident();
        set_rom(1'b1);
        pulse_init();
        model_run(LB);
        @(negedge clk);
        b_base  = cyc;
        b_run   = 1'b1;
        b_start = 1'b1;
        until_rel(b_base, 8 * LB + 6);
        chk("wrap_finish_cycle", b_fin, 8 * LB + 1);
        chk("wrap_writes", b_nwr, LB);
        begin
            int bad_ct = 0;
            int bad_s  = 0;
            for (int x = 0; x < LB; x++) if (b_ct[x] !== m_ct[x]) bad_ct++;
            for (int x = 0; x < 256; x++) if (b_smem[x] !== m_s[x]) bad_s++;
            chk("wrap_ct_ram_bad", bad_ct, 0);
            chk("wrap_s_ram_bad", bad_s, 0);
        end
        b_start = 1'b0;
        b_run   = 1'b0;
        @(negedge clk);
        #1;
        chk_zero_b("wrap_idle_after");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
